// File: rtl/frost32_ldst_unit.sv
`default_nettype none
// ============================================================================
// Module   : frost32_ldst_unit
// Purpose  : Frost32 memory-access stage. Takes one decoded load/store at a
//            time and checks its alignment. It runs one req/ack data-bus
//            transaction, formats load data by width and sign, and emits a
//            one-cycle write-back completion.
// Ports    : clk/rst          - clock, async active-high reset
//            in_*             - decoded op handshake (valid/ready), type,
//                               effective address, store data, dest index
//            mem_*            - registered data-bus request, ack/read data in
//            out_*            - completion pulse, reg write enable, dest
//                               index, formatted data, misalign flag
// Revision : 1.0 - initial release
// ============================================================================
module frost32_ldst_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_ldst_type,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [3:0]            in_dest_index,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_byte_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  output logic                  out_reg_we,
  output logic [3:0]            out_dest_index,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_misalign
);

  localparam logic [2:0] c_LD32  = 3'd0;
  localparam logic [2:0] c_LDU16 = 3'd1;
  localparam logic [2:0] c_LDS16 = 3'd2;
  localparam logic [2:0] c_LDU8  = 3'd3;
  localparam logic [2:0] c_LDS8  = 3'd4;
  localparam logic [2:0] c_ST32  = 3'd5;
  localparam logic [2:0] c_ST16  = 3'd6;
  localparam logic [2:0] c_ST8   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [2:0]      type_q;
  logic [1:0]      addr_lo_q;
  logic [3:0]      dest_q;

  // Decode of the incoming op, used only at accept time.
  logic            w_is_store;
  logic            w_is_word;
  logic            w_is_half;
  logic            w_misalign;
  logic [3:0]      w_byte_en;
  logic [31:0]     w_wdata;

  always_comb begin
    w_is_store = (in_ldst_type == c_ST32) || (in_ldst_type == c_ST16) ||
                 (in_ldst_type == c_ST8);
    w_is_word  = (in_ldst_type == c_LD32) || (in_ldst_type == c_ST32);
    w_is_half  = (in_ldst_type == c_LDU16) || (in_ldst_type == c_LDS16) ||
                 (in_ldst_type == c_ST16);
    w_misalign = 1'b0;
    w_byte_en  = 4'b0001 << in_addr[1:0];
    if (w_is_word) begin
      w_misalign = |in_addr[1:0];
      w_byte_en  = 4'b1111;
    end else if (w_is_half) begin
      w_misalign = in_addr[0];
      w_byte_en  = in_addr[1] ? 4'b1100 : 4'b0011;
    end
    // Lane replication lets the bus pick the lane purely from byte enables.
    w_wdata = 32'h0;
    if (w_is_store) begin
      if (w_is_word)      w_wdata = in_store_data;
      else if (w_is_half) w_wdata = {2{in_store_data[15:0]}};
      else                w_wdata = {4{in_store_data[7:0]}};
    end
  end

  // Load formatting from the latched type/address and the word on the bus.
  logic            w_q_is_store;
  logic [15:0]     w_half;
  logic [7:0]      w_byte;
  logic [31:0]     w_load_data;

  always_comb begin
    w_q_is_store = (type_q == c_ST32) || (type_q == c_ST16) || (type_q == c_ST8);
    w_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (addr_lo_q)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    case (type_q)
      c_LD32:  w_load_data = mem_rdata;
      c_LDU16: w_load_data = {16'h0, w_half};
      c_LDS16: w_load_data = {{16{w_half[15]}}, w_half};
      c_LDU8:  w_load_data = {24'h0, w_byte};
      c_LDS8:  w_load_data = {{24{w_byte[7]}}, w_byte};
      default: w_load_data = 32'h0;
    endcase
  end

  assign in_ready = (state_q == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      type_q         <= 3'd0;
      addr_lo_q      <= 2'd0;
      dest_q         <= 4'd0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_byte_en    <= 4'd0;
      mem_wdata      <= '0;
      out_valid      <= 1'b0;
      out_reg_we     <= 1'b0;
      out_dest_index <= 4'd0;
      out_data       <= '0;
      out_misalign   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            type_q    <= in_ldst_type;
            addr_lo_q <= in_addr[1:0];
            dest_q    <= in_dest_index;
            if (w_misalign) begin
              // Fault completes without touching the bus.
              state_q        <= S_DONE;
              out_valid      <= 1'b1;
              out_misalign   <= 1'b1;
              out_reg_we     <= 1'b0;
              out_data       <= '0;
              out_dest_index <= in_dest_index;
            end else begin
              state_q     <= S_REQ;
              mem_req     <= 1'b1;
              mem_we      <= w_is_store;
              mem_addr    <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_byte_en <= w_byte_en;
              mem_wdata   <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            state_q        <= S_DONE;
            mem_req        <= 1'b0;
            out_valid      <= 1'b1;
            out_misalign   <= 1'b0;
            out_reg_we     <= ~w_q_is_store;
            out_data       <= w_q_is_store ? 32'h0 : w_load_data;
            out_dest_index <= dest_q;
          end
        end
        S_DONE: begin
          out_valid <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/frost32_ldst_unit.md
# frost32_ldst_unit

Memory-access stage of the Frost32 pipeline, directly downstream of the instruction decoder. It accepts one decoded group-5 load/store operation at a time, with the effective address already computed by execute. It runs one request/acknowledge transaction on the data bus, formats load data by width and sign, and returns a write-back result. While a transaction is outstanding it holds off the pipeline through `in_ready`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: bus and register width; fixed at 32, with 4 byte lanes.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  a decoded load/store is presented.
- `in_ready`  out  1  unit can accept; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_ldst_type`  in  3  LdstType encoding: 0 Ld32, 1 LdU16, 2 LdS16, 3 LdU8, 4 LdS8, 5 St32, 6 St16, 7 St8.
- `in_addr`  in  32  effective byte address.
- `in_store_data`  in  32  rC value to store; ignored for loads.
- `in_dest_index`  in  4  destination register index for loads.
- `mem_req`  out  1  bus request; held until acknowledged.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_byte_en`  out  4  byte-lane enables, little-endian (lane 0 = bits 7:0).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  transaction complete; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  read word.
- `out_valid`  out  1  one-cycle completion pulse.
- `out_reg_we`  out  1  1 when the completed op is a successful load.
- `out_dest_index`  out  4  register index to write.
- `out_data`  out  32  formatted load data; 0 for stores.
- `out_misalign`  out  1  completion was an alignment fault.

## Operation
- FSM states and transitions:
  - IDLE: on accept, latch all inputs. If the access is aligned, go to REQ. If misaligned, go to DONE with the fault flag set.
  - REQ: hold `mem_req=1`. On `mem_ack=1`, capture `mem_rdata` and go to DONE.
  - DONE: assert the output pulse, then go to IDLE.
- `in_ready` = 1 only in IDLE.
- Alignment rule:
  - 32-bit ops require `addr[1:0]==0`.
  - 16-bit ops require `addr[0]==0`.
  - 8-bit ops are always aligned.
  - A misaligned access never asserts `mem_req`. Its completion has `out_misalign=1`, `out_reg_we=0` and `out_data=0`.
- Byte enables:
  - 32-bit: 4'b1111.
  - 16-bit: `addr[1]` ? 4'b1100 : 4'b0011.
  - 8-bit: 4'b0001 << `addr[1:0]`.
- Write data:
  - St32 passes the data through.
  - St16 replicates `data[15:0]` twice.
  - St8 replicates `data[7:0]` four times.
  - `mem_wdata` is 0 for loads.
- Load formatting:
  - Select the addressed halfword or byte lane from the captured word.
  - LdU zero-extends; LdS sign-extends from bit 15 or bit 7; Ld32 passes through.
- `mem_we` = 1 for types 5–7.
- All `mem_*` outputs are registered and stay stable for the whole of REQ. `mem_ack` is ignored outside REQ.
- A completed store gives `out_valid=1`, `out_reg_we=0`, `out_data=0`.

## Timing
- Reset (async) values:
  - State = IDLE, so `in_ready=1`.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_byte_en`, `mem_wdata` = 0.
  - `out_valid`, `out_reg_we`, `out_misalign`, `out_data`, `out_dest_index` = 0.
- Aligned access:
  - Accept at edge 0; `mem_req` high from cycle 1.
  - Ack sampled at edge k ≥ 1; `out_valid` high in cycle k+1; `in_ready` high again in cycle k+2.
  - Zero-wait-state bus (ack in cycle 1): 3 cycles per operation.
- Misaligned access: accept at edge 0; `out_valid` and `out_misalign` high in cycle 1; `in_ready` high in cycle 2.
- Out outputs are valid only while `out_valid=1`; they hold their last value otherwise.
- Reset asserted in REQ drops `mem_req` immediately, without waiting for a clock edge. The pending operation is discarded with no completion pulse, and a late `mem_ack` is ignored.
- `in_valid` while `in_ready=0` is not consumed. The upstream stage holds it.

## Test plan
- LdS8 at `in_addr=0x103`, `mem_rdata=0x80112233`, ack in cycle 1 -> `mem_addr=0x100`, `mem_byte_en=4'b0001<<3` (4'b1000), and `out_data=0xFFFFFF80` with `out_reg_we=1` in cycle 2.
- LdU16 at 0x202, `mem_rdata=0xBEEF1234` -> `mem_byte_en=4'b1100`, `out_data=0x0000BEEF`. LdS16 with the same inputs -> `out_data=0xFFFFBEEF`.
- St8 at 0x301 with data 0x000000A5 -> `mem_we=1`, `mem_byte_en=4'b0010`, `mem_wdata=0xA5A5A5A5`. Completion has `out_reg_we=0`.
- Ld32 at 0x402 -> `mem_req` never asserts; `out_valid=1`, `out_misalign=1` in cycle 1; `in_ready=1` in cycle 2.
- 5-cycle ack delay on St32 at 0x500 -> all `mem_*` outputs stable for 5 cycles and `in_ready=0` throughout. A second `in_valid` held during this time is accepted only after completion.
- `rst` pulsed mid-REQ -> `mem_req=0` asynchronously, no `out_valid`, `in_ready=1`; an ack arriving after reset is ignored.
